dds_sweep_ctrl: RTL and testbench

Frequency-sweep controller that generates the stream of signed phase-increment (tuning) words consumed by the Taylor-series DDS. It sits directly upstream of the DDS `din`/`din_valid`/`din_ready` port and produces a linear stepped sweep from a start to a stop tuning word. Each step is held for a programmable number of output samples, with single-shot or continuous repeat.

---
 rtl/dds_sweep_ctrl_if.sv | 21 ++
 rtl/dds_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// Tuning-word stream from the sweep controller to the DDS din port.
// Master drives word and valid, slave returns ready.
interface dds_sweep_ctrl_if #(
  parameter int G_FTW_WIDTH = 24
) ();
  logic [G_FTW_WIDTH-1:0] dout;
  logic                   dout_valid;
  logic                   dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear stepped DDS frequency sweep with per-step dwell and repeat.
// Define DDS_SWEEP_TRIANGLE_EN to enable the up/down (REV) sweep leg.
module dds_sweep_ctrl #(
  parameter int G_FTW_WIDTH   = 24,
  parameter int G_DWELL_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [G_FTW_WIDTH-1:0]   start_ftw,
  input  logic [G_FTW_WIDTH-1:0]   stop_ftw,
  input  logic [G_FTW_WIDTH-1:0]   step_ftw,
  input  logic [G_DWELL_WIDTH-1:0] dwell,
  input  logic                     continuous,
  input  logic                     triangle,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  dds_sweep_ctrl_if.master         dout_if
);

  localparam int W  = G_FTW_WIDTH;
  localparam int DW = G_DWELL_WIDTH;
  // Two guard bits keep ftw +/- step exact for any step magnitude
  localparam int XW = W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
`ifdef DDS_SWEEP_TRIANGLE_EN
  localparam logic [1:0] S_REV  = 2'd2;
`endif

  logic [1:0]    state;
  logic [W-1:0]  ftw;
  logic [DW-1:0] dcnt;
  logic [W-1:0]  start_r;
  logic [W-1:0]  stop_r;
  logic [W-1:0]  step_r;
  logic [DW-1:0] dwell_r;
  logic          cont_r;
  logic          dir_up;

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic          tri_r;
`else
  logic          unused_triangle;
  assign unused_triangle = triangle;
`endif

  logic                 hs;
  logic                 last;
  logic                 degen;
  logic [DW-1:0]        dwell_eff;
  logic signed [XW-1:0] xftw;
  logic signed [XW-1:0] xstep;
  logic signed [XW-1:0] xstart;
  logic signed [XW-1:0] xstop;
  logic signed [XW-1:0] fwd_next;
  logic                 fwd_past;

  assign hs        = dout_if.dout_valid & dout_if.dout_ready;
  assign dwell_eff = (dwell_r == '0) ? DW'(1) : dwell_r;
  assign last      = (dcnt == dwell_eff - DW'(1));
  assign degen     = (step_r == '0) || (start_r == stop_r);

  assign xftw   = {{2{ftw[W-1]}}, ftw};
  assign xstart = {{2{start_r[W-1]}}, start_r};
  assign xstop  = {{2{stop_r[W-1]}}, stop_r};
  assign xstep  = {2'b00, step_r};

  assign fwd_next = dir_up ? xftw + xstep : xftw - xstep;
  assign fwd_past = dir_up ? (fwd_next > xstop)
                           : (fwd_next < xstop);

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic signed [XW-1:0] rev_next;
  logic                 rev_past;

  assign rev_next = dir_up ? xftw - xstep : xftw + xstep;
  assign rev_past = dir_up ? (rev_next < xstart)
                           : (rev_next > xstart);
`endif

  assign dout_if.dout       = ftw;
  assign dout_if.dout_valid = (state != S_IDLE);
  assign busy               = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ftw     <= '0;
      dcnt    <= '0;
      start_r <= '0;
      stop_r  <= '0;
      step_r  <= '0;
      dwell_r <= '0;
      cont_r  <= 1'b0;
      dir_up  <= 1'b0;
      done    <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
      tri_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
        dcnt  <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              start_r <= start_ftw;
              stop_r  <= stop_ftw;
              step_r  <= step_ftw;
              dwell_r <= dwell;
              cont_r  <= continuous;
              dir_up  <= ($signed(stop_ftw) >= $signed(start_ftw));
`ifdef DDS_SWEEP_TRIANGLE_EN
              tri_r   <= triangle;
`endif
              ftw     <= start_ftw;
              dcnt    <= '0;
              state   <= S_FWD;
            end
          end
          S_FWD: begin
            if (hs) begin
              if (!last) begin
                dcnt <= dcnt + DW'(1);
              end else begin
                dcnt <= '0;
                if (!degen && !fwd_past) begin
                  ftw <= fwd_next[W-1:0];
`ifdef DDS_SWEEP_TRIANGLE_EN
                end else if (tri_r && !degen && !rev_past) begin
                  // turn around without repeating the stop-side word
                  state <= S_REV;
                  ftw   <= rev_next[W-1:0];
`endif
                end else if (cont_r) begin
                  ftw <= start_r;
                end else begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end
              end
            end
          end
`ifdef DDS_SWEEP_TRIANGLE_EN
          S_REV: begin
            if (hs) begin
              if (!last) begin
                dcnt <= dcnt + DW'(1);
              end else begin
                dcnt <= '0;
                if (!rev_past) begin
                  ftw <= rev_next[W-1:0];
                end else if (cont_r) begin
                  ftw   <= start_r;
                  state <= S_FWD;
                end else begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end
              end
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed vector bench for dds_sweep_ctrl: table of sweeps plus
// hand sequences for backpressure, continuous wrap and aborts.
module tb_dds_sweep_ctrl;
  localparam int W  = 24;
  localparam int DW = 16;

  typedef struct packed {
    logic [W-1:0]       start;
    logic [W-1:0]       stop;
    logic [W-1:0]       step;
    logic [DW-1:0]      dwell;
    logic               tri_en;
    logic [3:0]         n;
    logic [7:0][W-1:0]  exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [W-1:0]  start_ftw;
  logic [W-1:0]  stop_ftw;
  logic [W-1:0]  step_ftw;
  logic [DW-1:0] dwell;
  logic          continuous;
  logic          triangle;
  logic          start;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] got[$];
  vec_t         tbl[8];

  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.G_FTW_WIDTH(W)) dif ();

  dds_sweep_ctrl #(
    .G_FTW_WIDTH  (W),
    .G_DWELL_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start_ftw (start_ftw),
    .stop_ftw  (stop_ftw),
    .step_ftw  (step_ftw),
    .dwell     (dwell),
    .continuous(continuous),
    .triangle  (triangle),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dout_if   (dif)
  );

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic vec_t mk(input int s, input int p, input int st,
                              input int d, input bit t, input int n,
                              input int w0, input int w1 = 0,
                              input int w2 = 0, input int w3 = 0,
                              input int w4 = 0, input int w5 = 0,
                              input int w6 = 0, input int w7 = 0);
    vec_t v;
    v.start  = s[W-1:0];
    v.stop   = p[W-1:0];
    v.step   = st[W-1:0];
    v.dwell  = d[DW-1:0];
    v.tri_en = t;
    v.n      = n[3:0];
    v.exp[0] = w0[W-1:0];
    v.exp[1] = w1[W-1:0];
    v.exp[2] = w2[W-1:0];
    v.exp[3] = w3[W-1:0];
    v.exp[4] = w4[W-1:0];
    v.exp[5] = w5[W-1:0];
    v.exp[6] = w6[W-1:0];
    v.exp[7] = w7[W-1:0];
    return v;
  endfunction

  task automatic run(input vec_t v, input bit rnd);
    bit           hs_prev;
    bit           stalled;
    bit           seen;
    logic [W-1:0] held;
    int           lim;
    got.delete();
    start_ftw  = v.start;
    stop_ftw   = v.stop;
    step_ftw   = v.step;
    dwell      = v.dwell;
    triangle   = v.tri_en;
    continuous = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", longint'(busy), 1);
    chk("valid_rise", longint'(dif.dout_valid), 1);
    hs_prev = 1'b0;
    stalled = 1'b0;
    seen    = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (done) begin
        seen = 1'b1;
        chk("done_after_hs", longint'(hs_prev), 1);
        chk("busy_at_done", longint'(busy), 0);
        chk("valid_at_done", longint'(dif.dout_valid), 0);
      end else begin
        if (stalled) chk("stall_hold", sx(dif.dout), sx(held));
        dif.dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        hs_prev = dif.dout_valid && dif.dout_ready;
        stalled = dif.dout_valid && !dif.dout_ready;
        held    = dif.dout;
        if (hs_prev) got.push_back(dif.dout);
        @(posedge clk); #1;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", longint'(done), 0);
    chk("word_count", longint'(got.size()), longint'(v.n));
    lim = (got.size() < int'(v.n)) ? got.size() : int'(v.n);
    for (int i = 0; i < lim; i++)
      chk($sformatf("word%0d", i), sx(got[i]), sx(v.exp[i]));
  endtask

  initial begin
    tbl[0] = mk(100, 400, 100, 2, 0, 8,
                100, 100, 200, 200, 300, 300, 400, 400);
    tbl[1] = mk(100, 350, 100, 2, 0, 6,
                100, 100, 200, 200, 300, 300);
    tbl[2] = mk(0, -300, 150, 1, 0, 3, 0, -150, -300);
    tbl[3] = mk(-8388000, -8388608, 300, 1, 0, 3,
                -8388000, -8388300, -8388600);
    tbl[4] = mk(8388000, 8388607, 300, 1, 0, 3,
                8388000, 8388300, 8388600);
    tbl[5] = mk(5, 50, 0, 3, 0, 3, 5, 5, 5);
    tbl[6] = mk(-8388608, 8388607, 16777215, 0, 0, 2,
                -8388608, 8388607);
`ifdef DDS_SWEEP_TRIANGLE_EN
    tbl[7] = mk(100, 400, 100, 1, 1, 7,
                100, 200, 300, 400, 300, 200, 100);
`else
    tbl[7] = mk(100, 400, 100, 1, 1, 4, 100, 200, 300, 400);
`endif

    reset          = 1'b1;
    enable         = 1'b1;
    start          = 1'b0;
    start_ftw      = '0;
    stop_ftw       = '0;
    step_ftw       = '0;
    dwell          = '0;
    continuous     = 1'b0;
    triangle       = 1'b0;
    dif.dout_ready = 1'b1;
    #1;
    chk("rst_dout", sx(dif.dout), 0);
    chk("rst_valid", longint'(dif.dout_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) run(tbl[t], 1'b0);

    // same up sweep under random backpressure
    for (int r = 0; r < 3; r++) run(tbl[0], 1'b1);

    // continuous wrap, start pulse ignored while busy
    dif.dout_ready = 1'b1;
    start_ftw  = 24'd100;
    stop_ftw   = 24'd400;
    step_ftw   = 24'd100;
    dwell      = 16'd1;
    continuous = 1'b1;
    triangle   = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("cont_valid", longint'(dif.dout_valid), 1);
      chk($sformatf("cont_word%0d", i), sx(dif.dout),
          longint'(100 * ((i % 4) + 1)));
      start_ftw = (i == 2) ? 24'd999 : 24'd100;
      start     = (i == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", longint'(dif.dout_valid), 0);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    enable = 1'b1;
    continuous = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", longint'(done), 0);
      @(posedge clk); #1;
    end

    // restart after abort, then async reset mid-sweep
    run(tbl[2], 1'b0);
    start_ftw = 24'd100;
    stop_ftw  = 24'd400;
    step_ftw  = 24'd100;
    dwell     = 16'd2;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_dout", sx(dif.dout), 0);
    chk("mid_rst_valid", longint'(dif.dout_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_done", longint'(done), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", longint'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
